// File: rtl/wb_xbar_n.sv
// Single-master, N-slave classic Wishbone interconnect: parameterised address map,
// registered slave-side request, per-transaction timeout and saturating error count.
module wb_xbar_n_dec #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] adr,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] mask,
  output logic          hit
);
  assign hit = ((adr & mask) == base);
endmodule

module wb_xbar_n #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hF000_0000}},
  parameter int TIMEOUT = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            m_adr_i,
  input  logic [DATA_WIDTH-1:0]            m_dat_i,
  input  logic                             m_we_i,
  input  logic [DATA_WIDTH/8-1:0]          m_sel_i,
  input  logic                             m_stb_i,
  input  logic                             m_cyc_i,
  output logic [DATA_WIDTH-1:0]            m_dat_o,
  output logic                             m_ack_o,
  output logic                             m_err_o,
  output logic [ADDR_WIDTH-1:0]            s_adr_o,
  output logic [DATA_WIDTH-1:0]            s_dat_o,
  output logic                             s_we_o,
  output logic [DATA_WIDTH/8-1:0]          s_sel_o,
  output logic [NUM_SLAVES-1:0]            s_cyc_o,
  output logic [NUM_SLAVES-1:0]            s_stb_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]            s_ack_i,
  input  logic [NUM_SLAVES-1:0]            s_err_i,
  output logic                             busy_o,
  output logic [7:0]                       err_count_o
);
  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
    logic                  we;
    logic [SW-1:0]         sel;
  } req_t;

  state_e                state_q, state_d;
  req_t                  req_q, req_d;
  logic [IW-1:0]         idx_q, idx_d, hit_idx;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rerr_q, rerr_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic [7:0]            ecnt_q, ecnt_d;
  logic [NUM_SLAVES-1:0] hit;
  logic                  hit_any;

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_dec
    wb_xbar_n_dec #(.AW(ADDR_WIDTH)) u_dec (
      .adr  (m_adr_i),
      .base (SLAVE_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .mask (SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .hit  (hit[k])
    );
  end

  // Walk downwards so the lowest matching index is the last one written.
  always_comb begin
    hit_any = |hit;
    hit_idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--)
      if (hit[k]) hit_idx = IW'(k);
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rerr_d  = rerr_q;
    rdat_d  = rdat_q;
    ecnt_d  = ecnt_q;
    if (m_err_o && ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
    unique case (state_q)
      IDLE: if (m_cyc_i && m_stb_i) begin
        req_d.adr = m_adr_i;
        req_d.dat = m_dat_i;
        req_d.we  = m_we_i;
        req_d.sel = m_sel_i;
        idx_d     = hit_idx;
        cnt_d     = '0;
        rerr_d    = !hit_any;
        state_d   = hit_any ? ACCESS : RESP;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else if (s_err_i[idx_q]) begin
          rerr_d  = 1'b1;
          state_d = RESP;
        end else if (s_ack_i[idx_q]) begin
          rerr_d  = 1'b0;
          state_d = RESP;
          if (!req_q.we) rdat_d = s_dat_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
          rerr_d  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rerr_q  <= 1'b0;
      rdat_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rerr_q  <= rerr_d;
      rdat_q  <= rdat_d;
      ecnt_q  <= ecnt_d;
    end
  end

  // Strobes decode straight from the state flop so reset clears them asynchronously.
  assign s_stb_o     = (state_q == ACCESS) ? (NUM_SLAVES'(1) << idx_q) : '0;
  assign s_cyc_o     = s_stb_o;
  assign m_ack_o     = (state_q == RESP) && !rerr_q;
  assign m_err_o     = (state_q == RESP) && rerr_q;
  assign busy_o      = (state_q != IDLE);
  assign m_dat_o     = rdat_q;
  assign err_count_o = ecnt_q;
  assign s_adr_o     = req_q.adr;
  assign s_dat_o     = req_q.dat;
  assign s_we_o      = req_q.we;
  assign s_sel_o     = req_q.sel;
endmodule

// File: tb/tb_wb_xbar_n.sv
// Directed bench for wb_xbar_n: a transaction-level model predicts every cycle's
// outputs from the address map and timing rules; a negedge process compares.
module tb_wb_xbar_n;
  localparam int TMO = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  m_adr = '0, m_dat = '0;
  logic         m_we = 1'b0, m_stb = 1'b0, m_cyc = 1'b0;
  logic [3:0]   m_sel = '0;
  logic [127:0] s_dat = '0;
  logic [3:0]   s_ack = '0, s_err = '0;

  logic [31:0]  m_dat_o, s_adr_o, s_dat_o;
  logic         m_ack_o, m_err_o, s_we_o, busy_o;
  logic [3:0]   s_sel_o, s_cyc_o, s_stb_o;
  logic [7:0]   err_count_o;

  wb_xbar_n #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_stb_i(m_stb), .m_cyc_i(m_cyc),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .busy_o(busy_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state and per-cycle expectations
  bit          chk_en = 1'b0;
  logic [31:0] mdl_dat = '0, mdl_adr = '0, mdl_wdat = '0;
  logic        mdl_we = 1'b0;
  logic [3:0]  mdl_sel = '0;
  logic [7:0]  mdl_ecnt = '0;
  logic [3:0]  exp_stb = '0;
  logic        exp_ack = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
  logic [31:0] exp_dat = '0;
  logic [7:0]  exp_ecnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("ack",  32'(m_ack_o),     32'(exp_ack));
    chk("err",  32'(m_err_o),     32'(exp_err));
    chk("stb",  32'(s_stb_o),     32'(exp_stb));
    chk("cyc",  32'(s_cyc_o),     32'(exp_stb));
    chk("busy", 32'(busy_o),      32'(exp_busy));
    chk("mdat", m_dat_o,          exp_dat);
    chk("ecnt", 32'(err_count_o), 32'(exp_ecnt));
    chk("sadr", s_adr_o,          mdl_adr);
    chk("sdat", s_dat_o,          mdl_wdat);
    chk("swe",  32'(s_we_o),      32'(mdl_we));
    chk("ssel", 32'(s_sel_o),     32'(mdl_sel));
  end

  // Default map: 4 slaves on the top nibble, 0..3 each own 256 MiB.
  function automatic int decode(input logic [31:0] a);
    int n;
    n = int'(a[31:28]);
    return (n < 4) ? n : -1;
  endfunction

  task automatic set_exp(input logic [3:0] stb, input logic busy, input logic ack, input logic err);
    exp_stb  = stb;
    exp_busy = busy;
    exp_ack  = ack;
    exp_err  = err;
    exp_dat  = mdl_dat;
    exp_ecnt = mdl_ecnt;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      m_cyc = 1'b0; m_stb = 1'b0;
      s_ack = '0; s_err = '0;
      set_exp(4'h0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // kind: 0 slave acks, 1 slave errors, 2 slave silent. Slave answers after w wait
  // states. abrt>0 drops m_cyc in that cycle. noise drives ack/err on other slaves.
  task automatic run(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                     input logic [3:0] sel, input int kind, input int w, input int abrt,
                     input logic [31:0] rdata, input bit noise);
    int k, resp, last;
    bit eerr;
    logic [3:0] oh;
    k    = decode(adr);
    oh   = (k >= 0) ? 4'(1 << k) : 4'h0;
    eerr = 1'b1;
    resp = -1;
    if (k < 0)            resp = 1;
    else if (abrt > 0)    resp = -1;
    else if (kind == 0) begin resp = 2 + w; eerr = 1'b0; end
    else if (kind == 1)   resp = 2 + w;
    else                  resp = TMO + 1;
    last = (resp < 0) ? abrt : resp;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      m_adr = adr; m_dat = dat; m_we = we; m_sel = sel;
      m_cyc = !(abrt > 0 && c >= abrt);
      m_stb = m_cyc;
      s_ack = noise ? ~oh : 4'h0;
      s_err = noise ? ~oh : 4'h0;
      for (int j = 0; j < 4; j++) s_dat[j*32 +: 32] = ~rdata;
      if (k >= 0) s_dat[k*32 +: 32] = rdata;
      if (k >= 0 && kind < 2 && c == 1 + w && resp > 0) begin
        if (kind == 0) s_ack[k] = 1'b1;
        else           s_err[k] = 1'b1;
      end
      if (c == 1) begin
        mdl_adr = adr; mdl_wdat = dat; mdl_we = we; mdl_sel = sel;
      end
      if (c == resp && !eerr && !we) mdl_dat = rdata;
      set_exp((k >= 0 && c >= 1 && c != resp) ? oh : 4'h0, c >= 1,
              c == resp && !eerr, c == resp && eerr);
      if (c == resp && eerr && mdl_ecnt != 8'hFF) mdl_ecnt = mdl_ecnt + 8'd1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_ack",  32'(m_ack_o), 32'h0);
    chk("rst_err",  32'(m_err_o), 32'h0);
    chk("rst_mdat", m_dat_o, 32'h0);
    chk("rst_sadr", s_adr_o, 32'h0);
    chk("rst_stb",  32'(s_stb_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_ecnt", 32'(err_count_o), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    idle(2);

    run(32'h1000_0004, 32'h0, 1'b0, 4'hF, 0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    chk("t1_ack_lit", 32'(m_ack_o), 32'h1);
    chk("t1_dat_lit", m_dat_o, 32'hDEAD_BEEF);

    run(32'h0000_0010, 32'h1234_5678, 1'b1, 4'b0011, 0, 3, 0, 32'hBAD0_BAD0, 1'b1);
    @(negedge clk);
    chk("wr_ack_lit",  32'(m_ack_o), 32'h1);
    chk("wr_sel_lit",  32'(s_sel_o), 32'h3);
    chk("wr_sdat_lit", s_dat_o, 32'h1234_5678);
    chk("wr_mdat_lit", m_dat_o, 32'hDEAD_BEEF);

    run(32'h3000_0008, 32'h0, 1'b0, 4'hF, 0, 0, 0, 32'hCAFE_0003, 1'b0);

    run(32'h4000_0000, 32'h0, 1'b0, 4'hF, 0, 0, 0, 32'h0, 1'b0);
    @(negedge clk);
    chk("unm_err_lit", 32'(m_err_o), 32'h1);
    idle(1);
    @(negedge clk);
    chk("unm_ecnt_lit", 32'(err_count_o), 32'h1);

    run(32'h2000_0000, 32'h0, 1'b0, 4'hF, 1, 1, 0, 32'h0, 1'b0);

    run(32'h3000_0000, 32'h0, 1'b0, 4'hF, 2, 0, 3, 32'h0, 1'b0);
    run(32'h0000_0100, 32'h0, 1'b0, 4'hF, 0, 2, 0, 32'h0BAD_F00D, 1'b0);

    for (int i = 0; i < 260; i++)
      run(32'h8000_0000 + 32'(i), 32'h0, 1'b0, 4'hF, 0, 0, 0, 32'h0, 1'b0);
    idle(1);
    @(negedge clk);
    chk("sat_ecnt_lit", 32'(err_count_o), 32'hFF);

    run(32'h2000_0040, 32'h0, 1'b0, 4'hF, 2, 0, 0, 32'h0, 1'b1);
    @(negedge clk);
    chk("tmo_err_lit", 32'(m_err_o), 32'h1);
    idle(1);

    chk_en = 1'b0;
    @(posedge clk); #1;
    m_adr = 32'h1000_0020; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; s_ack = '0; s_err = '0;
    @(posedge clk); #1;
    chk("pre_rst_stb", 32'(s_stb_o), 32'h2);
    #2 rst = 1'b0;
    #1;
    chk("arst_stb",  32'(s_stb_o), 32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    chk("arst_mdat", m_dat_o, 32'h0);
    chk("arst_ecnt", 32'(err_count_o), 32'h0);
    chk("arst_sadr", s_adr_o, 32'h0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    mdl_dat = '0; mdl_adr = '0; mdl_wdat = '0; mdl_we = 1'b0; mdl_sel = '0; mdl_ecnt = '0;
    set_exp(4'h0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    idle(2);
    run(32'h1000_0000, 32'h0, 1'b0, 4'hF, 0, 1, 0, 32'h5555_AAAA, 1'b0);
    idle(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_xbar_n.md
# wb_xbar_n

Parametrised single-master, N-slave Wishbone (classic, non-pipelined) interconnect between the OpenMIPS core's Wishbone master port and the SOPC peripherals (base/ext RAM, flash, UART, digit display). It succeeds the fixed-map bus of the minimal SOPC with:
- a parameter-driven address map;
- registered slave strobes and master acknowledge;
- a per-transaction timeout that returns a bus error;
- error reporting back to the core.

## Interface
Parameters:
- NUM_SLAVES, 4, number of slave ports (1..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (multiple of 8).
- SLAVE_BASE, {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, packed NUM_SLAVES*ADDR_WIDTH; slice k is the base of slave k.
- SLAVE_MASK, {4{32'hF000_0000}}, packed; slice k is the decode mask of slave k.
- TIMEOUT, 255, maximum cycles in ACCESS before a forced error; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- m_adr_i  in  ADDR_WIDTH  master address.
- m_dat_i  in  DATA_WIDTH  master write data.
- m_we_i  in  1  write enable.
- m_sel_i  in  DATA_WIDTH/8  byte selects.
- m_stb_i, m_cyc_i  in  1  master strobe and cycle.
- m_dat_o  out  DATA_WIDTH  read data to master.
- m_ack_o  out  1  one-cycle acknowledge.
- m_err_o  out  1  one-cycle bus error.
- s_adr_o  out  ADDR_WIDTH  registered address, shared by all slaves.
- s_dat_o  out  DATA_WIDTH  registered write data, shared.
- s_we_o  out  1  registered write enable, shared.
- s_sel_o  out  DATA_WIDTH/8  registered byte selects, shared.
- s_cyc_o, s_stb_o  out  NUM_SLAVES  one-hot per-slave cycle and strobe.
- s_dat_i  in  NUM_SLAVES*DATA_WIDTH  packed slave read data.
- s_ack_i, s_err_i  in  NUM_SLAVES  per-slave acknowledge and error.
- busy_o  out  1  high whenever the state is not IDLE.
- err_count_o  out  8  saturating count of m_err_o pulses.

## Operation
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs read 0, including m_dat_o, s_* and err_count_o.
- Decode:
  - Slave k hits when (m_adr_i & MASK_k) == BASE_k.
  - If several slaves hit, the lowest index wins.
  - Decode is evaluated only in IDLE.
- IDLE:
  - Waits for m_cyc_i & m_stb_i.
  - When seen, latches adr/dat/we/sel into the s_* registers and captures the hit index.
  - Hit → ACCESS. No hit → RESP with the error flag set.
- ACCESS:
  - s_cyc_o[k] and s_stb_o[k] are held high.
  - The timeout counter increments each cycle, starting from 0 on entry.
  - Exit conditions, in priority order:
    1. m_cyc_i=0: abort. Strobes drop next cycle, → IDLE, no ack and no err.
    2. s_err_i[k]=1: → RESP with error.
    3. s_ack_i[k]=1: latch s_dat_i slice k into m_dat_o, → RESP with ack.
    4. Counter reaches TIMEOUT-1 (TIMEOUT≠0): → RESP with error.
  - Simultaneous ack and err from the slave resolve as err.
- RESP:
  - Strobes are low.
  - Exactly one of m_ack_o / m_err_o is high for one cycle, then → IDLE.
- Read data: m_dat_o holds its value until the next successful read. It is not updated on writes or errors.
- Error counter: err_count_o increments on each m_err_o pulse and saturates at 255.
- Ack/strobe on other slave ports (s_ack_i/s_err_i from non-selected slaves) is ignored.

## Timing
- Request sampled at the end of cycle 0.
- s_stb_o[k] is high from cycle 1.
- A slave acking combinationally in cycle 1 gives m_ack_o in cycle 2, so minimum latency is 2 cycles.
- A slave with W wait states gives m_ack_o in cycle 2+W.
- Timeout: with no slave response, m_err_o occurs in cycle TIMEOUT+1.
- Unmapped address: m_err_o in cycle 1.
- Back-to-back transactions: a new request can be sampled in the cycle after RESP, giving a throughput of one transfer per 3 cycles at zero wait.
- Reset asserted mid-ACCESS: strobes drop immediately (asynchronously); no ack or err is issued.

## Test plan
- Read at 0x1000_0004, slave 1 acks in its first strobe cycle with 0xDEAD_BEEF:
  - only s_stb_o[1] high in cycle 1;
  - m_ack_o in cycle 2 with m_dat_o=0xDEAD_BEEF;
  - busy_o high in cycles 1–2.
- Write 0x0000_0010, data 0x1234_5678, sel 4'b0011, slave 0 with 3 wait states:
  - s_dat_o=0x1234_5678, s_sel_o=0011, s_we_o=1;
  - m_ack_o in cycle 5;
  - m_dat_o unchanged.
- Access to 0x4000_0000 (unmapped):
  - no s_stb_o asserted;
  - m_err_o in cycle 1;
  - err_count_o 0→1.
- TIMEOUT=255, slave 2 never responds: m_err_o in cycle 256, s_stb_o[2] low from cycle 256. With err_count_o preloaded to 255 by prior errors, it stays at 255.
- m_cyc_i dropped in cycle 3 of a slave-3 access:
  - s_stb_o[3] low in cycle 4;
  - no ack or err;
  - next request served normally.
- Reset pulse (rst=0) during ACCESS:
  - all outputs 0 asynchronously;
  - state IDLE after release.
